// File: rtl/speech_source_pkg.sv
// Shared constants and helpers for the Speech256 excitation source:
// LFSR geometry and default seed, default noise pseudo-period, and the
// sample/amplitude/period widths shared with the controller and filter.
package speech_source_pkg;

    localparam int LFSR_W               = 17;
    localparam int LFSR_TAP_HI          = 16;   // x^17 term
    localparam int LFSR_TAP_LO          = 13;   // x^14 term
    localparam int NOISE_PERIOD_DEFAULT = 64;
    localparam int PER_W                = 8;
    localparam int AMP_W                = 16;
    localparam int SAMPLE_W             = 16;

    typedef logic [LFSR_W-1:0] lfsr_t;

    localparam lfsr_t LFSR_SEED_DEFAULT = 17'h00001;

    // Excitation kind selected by the latched pitch period
    typedef enum logic {
        SRC_VOICED = 1'b0,
        SRC_NOISE  = 1'b1
    } src_mode_e;

    // One Fibonacci step of x^17 + x^14 + 1
    function automatic lfsr_t lfsr_step(input lfsr_t s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed becomes 1
    function automatic lfsr_t seed_fix(input lfsr_t s);
        return (s == '0) ? lfsr_t'(1) : s;
    endfunction

endpackage

// File: rtl/speech_source_if.sv
// Controller-to-source-to-filter bundle: sample tick, pitch period and
// amplitude in; signed excitation sample, its strobe and period-done out.
interface speech_source_if
    import speech_source_pkg::*;
#(
    parameter int OUT_W = SAMPLE_W
) ();

    logic                    strobe_in;
    logic [PER_W-1:0]        period_in;
    logic [AMP_W-1:0]        amp_in;
    logic signed [OUT_W-1:0] source_out;
    logic                    source_stb_out;
    logic                    period_done_out;

    // Controller side: issues ticks and parameters, receives samples
    modport master (
        output strobe_in, period_in, amp_in,
        input  source_out, source_stb_out, period_done_out
    );

    // Source side
    modport slave (
        input  strobe_in, period_in, amp_in,
        output source_out, source_stb_out, period_done_out
    );

endinterface

// File: rtl/speech_source_lfsr17.sv
// 17-bit Fibonacci noise generator (x^17 + x^14 + 1). Advances once per
// enabled clock; noise_bit is the current (pre-advance) LSB, which picks
// the sign of the noise sample.
module speech_lfsr17
    import speech_source_pkg::*;
#(
    parameter lfsr_t SEED = LFSR_SEED_DEFAULT
) (
    input  logic clk,
    input  logic rst_an,
    input  logic adv_en,
    output logic noise_bit
);

    localparam lfsr_t SEED_EFF = seed_fix(SEED);

    lfsr_t state_reg;

    // Shift register: reload seed on reset, step on each sample tick
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_reg <= SEED_EFF;
        end else if (adv_en) begin
            state_reg <= lfsr_step(state_reg);
        end
    end

    assign noise_bit = state_reg[0];

endmodule

// File: rtl/speech_source.sv
// Speech256 excitation source. Each sample tick produces one signed sample:
// a single +A pulse per pitch period when voiced, or +/-A LFSR noise over a
// fixed pseudo-period when period_in is 0. Period and amplitude are latched
// at the start of each period; a one-clock done pulse marks its last sample.
module speech_source
    import speech_source_pkg::*;
#(
    parameter int    NOISE_PERIOD = NOISE_PERIOD_DEFAULT,  // 1..256
    parameter lfsr_t LFSR_SEED    = LFSR_SEED_DEFAULT,
    parameter int    OUT_W        = SAMPLE_W
) (
    input  logic           clk,
    input  logic           rst_an,
    speech_source_if.slave bus
);

    localparam int               A_MAX      = (1 << (OUT_W - 1)) - 1;
    localparam logic [PER_W-1:0] NOISE_LOAD = PER_W'(NOISE_PERIOD - 1);

    logic [PER_W-1:0]        cnt_reg;
    logic [PER_W-1:0]        per_lat_reg;
    logic [AMP_W-1:0]        amp_lat_reg;
    logic signed [OUT_W-1:0] out_reg;
    logic                    stb_reg;
    logic                    done_reg;

    logic                    start;
    logic [PER_W-1:0]        eff_per;
    logic [AMP_W-1:0]        eff_amp;
    src_mode_e               mode;
    logic [PER_W-1:0]        cnt_next;
    logic signed [OUT_W-1:0] a_sat;
    logic signed [OUT_W-1:0] sample_next;
    logic                    done_next;
    logic                    noise_bit;

    speech_lfsr17 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_an   (rst_an),
        .adv_en   (bus.strobe_in),
        .noise_bit(noise_bit)
    );

    // Next-sample datapath; on a start tick the fresh inputs take effect at once
    always_comb begin
        start    = (cnt_reg == '0);
        eff_per  = start ? bus.period_in : per_lat_reg;
        eff_amp  = start ? bus.amp_in    : amp_lat_reg;
        mode     = (eff_per == '0) ? SRC_NOISE : SRC_VOICED;

        // period_in is nonzero on the voiced branch, so the decrement cannot wrap
        if (start) begin
            cnt_next = (bus.period_in == '0) ? NOISE_LOAD : bus.period_in - 1'b1;
        end else begin
            cnt_next = cnt_reg - 1'b1;
        end
        done_next = (cnt_next == '0);

        // Saturate rather than wrap so loud frames never flip sign
        if (32'(eff_amp) > 32'(A_MAX)) begin
            a_sat = OUT_W'(A_MAX);
        end else begin
            a_sat = OUT_W'(eff_amp);
        end

        sample_next = '0;
        if (mode == SRC_VOICED) begin
            if (start) begin
                sample_next = a_sat;
            end
        end else begin
            sample_next = noise_bit ? a_sat : -a_sat;
        end
    end

    // Period counter, parameter latches and registered outputs
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            cnt_reg     <= '0;
            per_lat_reg <= '0;
            amp_lat_reg <= '0;
            out_reg     <= '0;
            stb_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            stb_reg  <= 1'b0;
            done_reg <= 1'b0;
            if (bus.strobe_in) begin
                cnt_reg <= cnt_next;
                if (start) begin
                    per_lat_reg <= bus.period_in;
                    amp_lat_reg <= bus.amp_in;
                end
                out_reg  <= sample_next;
                stb_reg  <= 1'b1;
                done_reg <= done_next;
            end
        end
    end

    assign bus.source_out      = out_reg;
    assign bus.source_stb_out  = stb_reg;
    assign bus.period_done_out = done_reg;

endmodule
